// File: rtl/gd_iter_ctrl.sv
// gd_iter_ctrl: gradient-descent iteration controller for the polynomial
// function block. Launches an evaluation at x, takes the returned gradient,
// steps x by -(gradient >>> LR_SHIFT), and repeats until convergence,
// iteration limit, function overflow or handshake timeout.
// Optional feature macro: GD_BEST_TRACK_EN adds best_x/best_value tracking.
module gd_iter_ctrl #(
  parameter int                 LR_SHIFT       = 2,
  parameter logic signed [31:0] TOL            = 32'sd1,
  parameter int                 MAX_ITER       = 64,
  parameter int                 TIMEOUT_CYCLES = 1024
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [31:0] x_init,
  output logic        func_start,
  output logic [31:0] func_x,
  input  logic        func_done,
  input  logic [63:0] func_gradient,
  input  logic [63:0] func_value,
  input  logic        func_overflow,
  output logic        busy,
  output logic        done,
  output logic        converged,
  output logic        error,
  output logic        sat,
  output logic [31:0] x_out,
  output logic [63:0] value_out,
  output logic [15:0] iter_count
`ifdef GD_BEST_TRACK_EN
  ,output logic [31:0] best_x,
  output logic [63:0] best_value
`endif
);

  typedef enum logic [2:0] {IDLE, LAUNCH, WAIT, UPDATE, GAP, FIN} state_t;

  localparam logic signed [63:0] S32_MAX = 64'sh0000_0000_7FFF_FFFF;
  localparam logic signed [63:0] S32_MIN = 64'shFFFF_FFFF_8000_0000;
  localparam logic [31:0]        T_LAST  = 32'(TIMEOUT_CYCLES - 1);
  localparam logic [15:0]        ITER_LIM = 16'(MAX_ITER);

  state_t             state;
  logic signed [31:0] x;
  logic signed [63:0] grad_q;
  logic [63:0]        val_q;
  logic               ovf_q;
  logic [31:0]        timer;

  logic signed [63:0] step64;
  logic signed [31:0] step, step_abs, x_next;
  logic               step_sat, x_sat;
  logic [32:0]        diff;

  assign step64 = grad_q >>> LR_SHIFT;

  // Step/x arithmetic for the UPDATE decision: clamp step to 32 bits, then
  // form x - step in 33 bits and clamp back to the signed 32-bit range.
  always_comb begin
    step_sat = 1'b0;
    step     = step64[31:0];
    if (step64 > S32_MAX) begin
      step     = 32'sh7FFF_FFFF;
      step_sat = 1'b1;
    end else if (step64 < S32_MIN) begin
      step     = 32'sh8000_0000;
      step_sat = 1'b1;
    end
    // most-negative step has no positive twin; treat its magnitude as max
    if (step == 32'sh8000_0000) step_abs = 32'sh7FFF_FFFF;
    else if (step[31])          step_abs = -step;
    else                        step_abs = step;
    diff   = {x[31], x} - {step[31], step};
    x_sat  = diff[32] != diff[31];
    x_next = x_sat ? (diff[32] ? 32'sh8000_0000 : 32'sh7FFF_FFFF) : diff[31:0];
  end

`ifdef GD_BEST_TRACK_EN
  logic best_vld;
`endif

  // Main control FSM; all outputs are registered here.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      x          <= '0;
      grad_q     <= '0;
      val_q      <= '0;
      ovf_q      <= 1'b0;
      timer      <= '0;
      func_start <= 1'b0;
      func_x     <= '0;
      busy       <= 1'b0;
      done       <= 1'b0;
      converged  <= 1'b0;
      error      <= 1'b0;
      sat        <= 1'b0;
      x_out      <= '0;
      value_out  <= '0;
      iter_count <= '0;
`ifdef GD_BEST_TRACK_EN
      best_vld   <= 1'b0;
      best_x     <= '0;
      best_value <= '0;
`endif
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: if (start) begin
          x          <= x_init;
          converged  <= 1'b0;
          error      <= 1'b0;
          sat        <= 1'b0;
          iter_count <= '0;
          busy       <= 1'b1;
`ifdef GD_BEST_TRACK_EN
          best_vld   <= 1'b0;
          best_x     <= '0;
          best_value <= '0;
`endif
          state      <= LAUNCH;
        end
        LAUNCH: begin
          func_start <= 1'b1;
          func_x     <= x;
          timer      <= '0;
          state      <= WAIT;
        end
        WAIT: begin
          if (func_done) begin
            grad_q     <= func_gradient;
            val_q      <= func_value;
            ovf_q      <= func_overflow;
            iter_count <= iter_count + 16'd1;
            func_start <= 1'b0;
            state      <= UPDATE;
          end else if (timer == T_LAST) begin
            func_start <= 1'b0;
            error      <= 1'b1;
            x_out      <= x;
            value_out  <= val_q;
            done       <= 1'b1;
            state      <= FIN;
          end else begin
            timer <= timer + 32'd1;
          end
        end
        UPDATE: begin
          if (ovf_q) begin
            error     <= 1'b1;
            x_out     <= x;
            value_out <= val_q;
            done      <= 1'b1;
            state     <= FIN;
          end else begin
`ifdef GD_BEST_TRACK_EN
            if (!best_vld || ($signed(val_q) < $signed(best_value))) begin
              best_vld   <= 1'b1;
              best_x     <= x;
              best_value <= val_q;
            end
`endif
            if (step_sat) sat <= 1'b1;
            if (step_abs <= TOL) begin
              converged <= 1'b1;
              x_out     <= x;
              value_out <= val_q;
              done      <= 1'b1;
              state     <= FIN;
            end else begin
              x <= x_next;
              if (x_sat) sat <= 1'b1;
              if (iter_count == ITER_LIM) begin
                x_out     <= x_next;
                value_out <= val_q;
                done      <= 1'b1;
                state     <= FIN;
              end else begin
                timer <= '0;
                state <= GAP;
              end
            end
          end
        end
        GAP: begin
          // func_start is already low; relaunch once the block drops done
          if (!func_done) begin
            state <= LAUNCH;
          end else if (timer == T_LAST) begin
            error     <= 1'b1;
            x_out     <= x;
            value_out <= val_q;
            done      <= 1'b1;
            state     <= FIN;
          end else begin
            timer <= timer + 32'd1;
          end
        end
        FIN: begin
          busy  <= 1'b0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_gd_iter_ctrl.sv
// Scoreboard bench for gd_iter_ctrl: a behavioural function block answers
// each launch (f = x^2, grad = 2x, or a constant huge gradient), expected
// run results are queued at start, and a monitor checks them on done.
module tb_gd_iter_ctrl;

  typedef struct packed {
    logic        conv;
    logic        err;
    logic        sat;
    logic [31:0] x;
    logic [15:0] it;
    logic [63:0] val;
    logic        chk_val;
  } res_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  int n_chk = 0;
  int n_fail = 0;

  // instance A: default limits; instance B: MAX_ITER = 4
  logic        a_start, a_fstart, a_fdone, a_fovf, a_busy, a_done, a_conv, a_err, a_sat;
  logic [31:0] a_xinit, a_fx, a_xout;
  logic [63:0] a_grad, a_fval, a_vout;
  logic [15:0] a_iter;
  logic        b_start, b_fstart, b_fdone, b_fovf, b_busy, b_done, b_conv, b_err, b_sat;
  logic [31:0] b_xinit, b_fx, b_xout;
  logic [63:0] b_grad, b_fval, b_vout;
  logic [15:0] b_iter;
`ifdef GD_BEST_TRACK_EN
  logic [31:0] a_bx, b_bx;
  logic [63:0] a_bv, b_bv;
`endif

  gd_iter_ctrl dut (
    .clk(clk), .rst(rst), .start(a_start), .x_init(a_xinit),
    .func_start(a_fstart), .func_x(a_fx), .func_done(a_fdone),
    .func_gradient(a_grad), .func_value(a_fval), .func_overflow(a_fovf),
    .busy(a_busy), .done(a_done), .converged(a_conv), .error(a_err), .sat(a_sat),
    .x_out(a_xout), .value_out(a_vout), .iter_count(a_iter)
`ifdef GD_BEST_TRACK_EN
    , .best_x(a_bx), .best_value(a_bv)
`endif
  );

  gd_iter_ctrl #(.MAX_ITER(4)) dut4 (
    .clk(clk), .rst(rst), .start(b_start), .x_init(b_xinit),
    .func_start(b_fstart), .func_x(b_fx), .func_done(b_fdone),
    .func_gradient(b_grad), .func_value(b_fval), .func_overflow(b_fovf),
    .busy(b_busy), .done(b_done), .converged(b_conv), .error(b_err), .sat(b_sat),
    .x_out(b_xout), .value_out(b_vout), .iter_count(b_iter)
`ifdef GD_BEST_TRACK_EN
    , .best_x(b_bx), .best_value(b_bv)
`endif
  );

  res_t        qa[$];
  res_t        qb[$];
  logic [31:0] exp_fx[$];
  int          a_mode = 0;    // 0: f=x^2, 1: constant huge gradient, 2: never answer
  int          a_ovf_at = 0;  // evaluation index that reports overflow (0 = none)
  int          a_neval = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
    end
  endtask

  function automatic logic [63:0] mgrad(input int mode, input logic [31:0] fx);
    longint xs;
    xs = longint'($signed(fx));
    if (mode == 1) return 64'h0000_7FFF_FFFF_FFFF;
    return 64'(xs * 2);
  endfunction

  function automatic logic [63:0] mval(input int mode, input logic [31:0] fx);
    longint xs;
    xs = longint'($signed(fx));
    if (mode == 1) return 64'd0;
    return 64'((xs * xs) >>> 8);
  endfunction

  task automatic cmp_res(input string tag, input res_t a, input res_t e);
    chk({tag, " converged"}, 64'(a.conv), 64'(e.conv));
    chk({tag, " error"}, 64'(a.err), 64'(e.err));
    chk({tag, " sat"}, 64'(a.sat), 64'(e.sat));
    chk({tag, " x_out"}, 64'(a.x), 64'(e.x));
    chk({tag, " iter_count"}, 64'(a.it), 64'(e.it));
    if (e.chk_val) chk({tag, " value_out"}, a.val, e.val);
  endtask

  // Function block model for instance A: answers one cycle after launch.
  initial begin
    a_fdone = 1'b0; a_grad = '0; a_fval = '0; a_fovf = 1'b0;
    forever begin
      @(negedge clk);
      if (a_fdone) begin
        a_fdone = 1'b0;
        a_fovf  = 1'b0;
      end else if (a_fstart && a_mode != 2) begin
        a_neval++;
        if (exp_fx.size() > 0) chk("func_x", 64'(a_fx), 64'(exp_fx.pop_front()));
        a_grad  = mgrad(a_mode, a_fx);
        a_fval  = mval(a_mode, a_fx);
        a_fovf  = (a_neval == a_ovf_at);
        a_fdone = 1'b1;
      end
    end
  end

  // Function block model for instance B: always f=x^2, no overflow.
  initial begin
    b_fdone = 1'b0; b_grad = '0; b_fval = '0; b_fovf = 1'b0;
    forever begin
      @(negedge clk);
      if (b_fdone) b_fdone = 1'b0;
      else if (b_fstart) begin
        b_grad  = mgrad(0, b_fx);
        b_fval  = mval(0, b_fx);
        b_fdone = 1'b1;
      end
    end
  end

  // Monitors: each done pulse pops one expected run result.
  always @(negedge clk) begin
    if (a_done) begin
      if (qa.size() == 0) chk("A unexpected done", 64'd1, 64'd0);
      else cmp_res("A", '{a_conv, a_err, a_sat, a_xout, a_iter, a_vout, 1'b0}, qa.pop_front());
    end
    if (b_done) begin
      if (qb.size() == 0) chk("B unexpected done", 64'd1, 64'd0);
      else cmp_res("B", '{b_conv, b_err, b_sat, b_xout, b_iter, b_vout, 1'b0}, qb.pop_front());
    end
  end

  task automatic pulse_a(input logic [31:0] xi);
    @(negedge clk);
    a_xinit = xi; a_start = 1'b1;
    @(negedge clk);
    a_start = 1'b0;
  endtask

  task automatic wait_a(input string nm);
    for (int i = 0; i < 3000 && qa.size() != 0; i++) @(negedge clk);
    if (qa.size() != 0) begin
      chk({nm, " run timeout"}, 64'd0, 64'd1);
      qa.delete();
    end
    @(negedge clk);
  endtask

  task automatic push_square_fx();
    logic [31:0] v;
    v = 32'h100;
    for (int i = 0; i < 8; i++) begin
      exp_fx.push_back(v);
      v = v >> 1;
    end
  endtask

  initial begin
    int cnt;
    a_start = 1'b0; a_xinit = '0; b_start = 1'b0; b_xinit = '0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    chk("reset busy", 64'(a_busy), 64'd0);
    chk("reset done", 64'(a_done), 64'd0);
    chk("reset func_start", 64'(a_fstart), 64'd0);
    chk("reset flags", 64'({a_conv, a_err, a_sat}), 64'd0);
    chk("reset x_out", 64'(a_xout), 64'd0);
    chk("reset value_out", a_vout, 64'd0);
    chk("reset iter_count", 64'(a_iter), 64'd0);

    // f=x^2 from 1.0 halves x each step until |step| reaches TOL at x=2/256;
    // value at 2/256 is 4/65536, below one Q56.8 lsb, so 0
    a_mode = 0; a_ovf_at = 0; a_neval = 0;
    push_square_fx();
    qa.push_back('{1'b1, 1'b0, 1'b0, 32'h2, 16'd8, 64'd0, 1'b1});
    pulse_a(32'h100);
    wait_a("converge");
    chk("converge leftover func_x", 64'(exp_fx.size()), 64'd0);

    // iteration limit 4: evaluations at 0x100..0x20, final x 0x10, f(0x20)=4
    qb.push_back('{1'b0, 1'b0, 1'b0, 32'h10, 16'd4, 64'd4, 1'b1});
    @(negedge clk);
    b_xinit = 32'h100; b_start = 1'b1;
    @(negedge clk);
    b_start = 1'b0;
    for (int i = 0; i < 500 && qb.size() != 0; i++) @(negedge clk);
    chk("maxiter run finished", 64'(qb.size()), 64'd0);

    // overflow on 3rd evaluation (x=0x40, f=0x10)
    a_ovf_at = 3; a_neval = 0;
    qa.push_back('{1'b0, 1'b1, 1'b0, 32'h40, 16'd3, 64'h10, 1'b1});
    pulse_a(32'h100);
    wait_a("overflow");
    a_ovf_at = 0;

    // handshake timeout: no answer
    a_mode = 2;
    qa.push_back('{1'b0, 1'b1, 1'b0, 32'h100, 16'd0, 64'd0, 1'b0});
    pulse_a(32'h100);
    for (int i = 0; i < 20 && !a_fstart; i++) begin @(posedge clk); #1; end
    chk("timeout func_start raised", 64'(a_fstart), 64'd1);
    cnt = 0;
    for (int i = 0; i < 2000 && !a_err; i++) begin @(posedge clk); #1; cnt++; end
    chk("timeout cycles", 64'(cnt), 64'd1024);
    wait_a("timeout");
    chk("timeout func_start low", 64'(a_fstart), 64'd0);
    chk("timeout busy low", 64'(a_busy), 64'd0);

    // saturation: step clamps to 0x7FFFFFFF, x clamps to 0x80000000 every step
    a_mode = 1; a_neval = 0;
    exp_fx.push_back(32'h8000_0010);
    exp_fx.push_back(32'h8000_0000);
    exp_fx.push_back(32'h8000_0000);
    qa.push_back('{1'b0, 1'b0, 1'b1, 32'h8000_0000, 16'd64, 64'd0, 1'b1});
    pulse_a(32'h8000_0010);
    repeat (20) @(negedge clk);
    pulse_a(32'h100);  // must be ignored mid-run
    wait_a("saturate");

    // reset in the middle of WAIT
    a_mode = 2;
    pulse_a(32'h100);
    for (int i = 0; i < 20 && !a_fstart; i++) @(negedge clk);
    repeat (3) @(negedge clk);
    #2 rst = 1'b1;
    #1;
    chk("midrst func_start", 64'(a_fstart), 64'd0);
    chk("midrst busy", 64'(a_busy), 64'd0);
    chk("midrst done", 64'(a_done), 64'd0);
    chk("midrst iter_count", 64'(a_iter), 64'd0);
    @(negedge clk);
    rst = 1'b0;
    a_mode = 0; a_neval = 0;
    push_square_fx();
    qa.push_back('{1'b1, 1'b0, 1'b0, 32'h2, 16'd8, 64'd0, 1'b1});
    pulse_a(32'h100);
    wait_a("post-reset");
    chk("post-reset leftover func_x", 64'(exp_fx.size()), 64'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
